// File: rtl/cic_lia_mc_pkg.sv
// Shared helpers for the multi-channel CIC decimator: internal width, output scaling and clip limits.
// Latency: none (pure functions, elaborated at compile time or combinationally).
// Backpressure: not applicable.
package cic_lia_mc_pkg;

    // Integrator/comb width that holds the full gain of the largest ratio without loss.
    function automatic int cic_width(input int input_width, input int n, input int rate_log2_max);
        return input_width + n * rate_log2_max;
    endfunction

    // Right-shift that normalises gain R^N back to unity for ratio 2^r (negative means left shift).
    function automatic int cic_shift(input int input_width, input int n, input int output_width, input int r);
        return input_width + n * r - output_width;
    endfunction

    // Most positive representable result.
    function automatic longint sat_max(input int output_width);
        return (longint'(1) <<< (output_width - 1)) - 1;
    endfunction

    // Most negative representable result.
    function automatic longint sat_min(input int output_width);
        return -(longint'(1) <<< (output_width - 1));
    endfunction

endpackage

// File: rtl/cic_lia_channel.sv
// One CIC channel: N integrators, N comb stages driven by the shared token pipeline, round/saturate.
// Latency: comb stage k registers k edges after the tap; the result registers one edge after stage N.
// Backpressure: none; integrators stall on in_valid low, comb stages run only when their token arrives.
module cic_lia_channel
    import cic_lia_mc_pkg::*;
#(
    parameter int N             = 2,
    parameter int RATE_LOG2_MAX = 4,
    parameter int INPUT_WIDTH   = 14,
    parameter int OUTPUT_WIDTH  = 14
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   in_valid,
    input  logic                                   tap,
    input  logic [$clog2(RATE_LOG2_MAX+1)-1:0]     r,
    input  logic [N-1:0]                           stage_en,
    input  logic                                   out_en,
    input  logic signed [INPUT_WIDTH-1:0]          in_data,
    output logic signed [OUTPUT_WIDTH-1:0]         out_data,
    output logic                                   sat
);

    localparam int W = cic_width(INPUT_WIDTH, N, RATE_LOG2_MAX);
    // Extra headroom so the rounding add and any left shift never overflow before the clip test.
    localparam int X = ((W > OUTPUT_WIDTH) ? W : OUTPUT_WIDTH) + 2;
    localparam logic signed [X-1:0] SAT_HI = X'(sat_max(OUTPUT_WIDTH));
    localparam logic signed [X-1:0] SAT_LO = X'(sat_min(OUTPUT_WIDTH));

    logic signed [W-1:0] integ     [N];
    logic signed [W-1:0] integ_nxt [N];
    logic signed [W-1:0] comb_y    [N+1];   // comb_y[0] is the sampled last integrator
    logic signed [W-1:0] comb_d    [N];
    logic signed [W-1:0] acc;
    logic signed [X-1:0] ext;
    logic signed [X-1:0] scaled;
    logic signed [X-1:0] res;
    logic                clip;
    int                  sh;

    // Integrator chain next values; the last stage already includes the sample accepted this edge.
    always_comb begin
        acc = W'(in_data);
        for (int k = 0; k < N; k++) begin
            acc          = integ[k] + acc;
            integ_nxt[k] = acc;
        end
    end

    // Gain normalisation with round-half-up, then clip to the output range.
    always_comb begin
        sh   = cic_shift(INPUT_WIDTH, N, OUTPUT_WIDTH, int'(r));
        ext  = X'(comb_y[N]);
        if (sh > 0) begin
            scaled = (ext + (X'(1) <<< (sh - 1))) >>> sh;
        end else begin
            scaled = ext <<< (-sh);
        end
        res  = scaled;
        clip = 1'b0;
        if (scaled > SAT_HI) begin
            res  = SAT_HI;
            clip = 1'b1;
        end else if (scaled < SAT_LO) begin
            res  = SAT_LO;
            clip = 1'b1;
        end
    end

    // Datapath state: integrators on accepted samples, tap capture, comb stages on token arrival.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < N; k++) begin
                integ[k]  <= '0;
                comb_d[k] <= '0;
            end
            for (int k = 0; k <= N; k++) begin
                comb_y[k] <= '0;
            end
        end else begin
            if (in_valid) begin
                for (int k = 0; k < N; k++) begin
                    integ[k] <= integ_nxt[k];
                end
            end
            if (tap) begin
                comb_y[0] <= integ_nxt[N-1];
            end
            for (int k = 0; k < N; k++) begin
                if (stage_en[k]) begin
                    comb_y[k+1] <= comb_y[k] - comb_d[k];
                    comb_d[k]   <= comb_y[k];
                end
            end
        end
    end

    // Output register and sticky clip flag survive rate changes; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            sat      <= 1'b0;
        end else if (out_en) begin
            out_data <= res[OUTPUT_WIDTH-1:0];
            if (clip) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_lia_mc.sv
// Multi-channel runtime-rate CIC decimator: shared counter, rate latch, warm-up and comb token pipeline.
// Latency: out_valid rises N+1 edges after the edge accepting the last sample of a frame.
// Backpressure: none; in_valid gaps stall integrators and counter, in-flight comb tokens still complete.
module cic_lia_mc
    import cic_lia_mc_pkg::*;
#(
    parameter int N             = 2,
    parameter int RATE_LOG2_MAX = 4,
    parameter int NCH           = 2,
    parameter int INPUT_WIDTH   = 14,
    parameter int OUTPUT_WIDTH  = 14
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [$clog2(RATE_LOG2_MAX+1)-1:0]   rate_log2,
    input  logic                                 in_valid,
    input  logic [NCH*INPUT_WIDTH-1:0]           in_data,
    output logic                                 out_valid,
    output logic [NCH*OUTPUT_WIDTH-1:0]          out_data,
    output logic [NCH-1:0]                       sat_flag
);

    localparam int RW = $clog2(RATE_LOG2_MAX + 1);
    localparam int CW = RATE_LOG2_MAX + 1;
    localparam int WC = $clog2(N + 1);

    logic [RW-1:0] r;
    logic [RW-1:0] rate_sat;
    logic [CW-1:0] cnt;
    logic [N:0]    tok;          // tok[k] set: comb stage k holds a fresh result
    logic [WC-1:0] warm;
    logic          rate_chg;
    logic          cnt_last;
    logic          tap;
    logic          out_en;

    // Requested ratios beyond the supported maximum fold onto the maximum.
    always_comb begin
        rate_sat = (rate_log2 > RW'(RATE_LOG2_MAX)) ? RW'(RATE_LOG2_MAX) : rate_log2;
    end

    assign rate_chg = (rate_sat != r);
    assign cnt_last = (cnt == CW'((1 << r) - 1));
    assign tap      = in_valid && cnt_last && !rate_chg;
    assign out_en   = tok[N] && (warm == WC'(N)) && !rate_chg;

    // Control: rate latch, frame counter, token shift and warm-up; reset and rate change restart all.
    always_ff @(posedge clk) begin
        if (rst || rate_chg) begin
            r         <= rate_sat;
            cnt       <= '0;
            tok       <= '0;
            warm      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                cnt <= cnt_last ? '0 : cnt + CW'(1);
            end
            tok <= {tok[N-1:0], tap};
            if (tok[N] && (warm != WC'(N))) begin
                warm <= warm + WC'(1);
            end
            out_valid <= out_en;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        cic_lia_channel #(
            .N             (N),
            .RATE_LOG2_MAX (RATE_LOG2_MAX),
            .INPUT_WIDTH   (INPUT_WIDTH),
            .OUTPUT_WIDTH  (OUTPUT_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clear    (rate_chg),
            .in_valid (in_valid),
            .tap      (tap),
            .r        (r),
            .stage_en (tok[N-1:0]),
            .out_en   (out_en),
            .in_data  (in_data[ch*INPUT_WIDTH +: INPUT_WIDTH]),
            .out_data (out_data[ch*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
            .sat      (sat_flag[ch])
        );
    end

endmodule

// File: tb/tb_cic_lia_mc.sv
// Bench for cic_lia_mc: two instances (full-width and 12-bit output) share stimulus.
// Expected outputs come from a boxcar^N convolution over the accepted-sample history.
// Every cycle is compared against the model, plus targeted value/timing checks per scenario.
module tb_cic_lia_mc;

    localparam int N    = 2;
    localparam int RMAX = 4;
    localparam int NCH  = 2;
    localparam int IW   = 14;
    localparam int OWA  = 14;
    localparam int OWB  = 12;

    logic                  clk       = 1'b0;
    logic                  rst       = 1'b1;
    logic [2:0]            rate_log2 = 3'd4;
    logic                  in_valid  = 1'b0;
    logic [NCH*IW-1:0]     in_data   = '0;
    logic                  vld_a, vld_b;
    logic [NCH*OWA-1:0]    dat_a;
    logic [NCH*OWB-1:0]    dat_b;
    logic [NCH-1:0]        sat_a, sat_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [NCH*IW-1:0]  hist[$];
    int                 m_r  = 4;
    int                 taps = 0;
    int                 pdue[$];
    logic [NCH*OWA-1:0] pa[$];
    logic [NCH*OWB-1:0] pb[$];
    logic [NCH-1:0]     psa[$];
    logic [NCH-1:0]     psb[$];
    logic               e_vld = 1'b0;
    logic [NCH*OWA-1:0] e_da  = '0;
    logic [NCH*OWB-1:0] e_db  = '0;
    logic [NCH-1:0]     e_sa  = '0;
    logic [NCH-1:0]     e_sb  = '0;

    always #5 clk = ~clk;

    cic_lia_mc #(.N(N), .RATE_LOG2_MAX(RMAX), .NCH(NCH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OWA)) dut_a (
        .clk(clk), .rst(rst), .rate_log2(rate_log2), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vld_a), .out_data(dat_a), .sat_flag(sat_a));

    cic_lia_mc #(.N(N), .RATE_LOG2_MAX(RMAX), .NCH(NCH), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OWB)) dut_b (
        .clk(clk), .rst(rst), .rate_log2(rate_log2), .in_valid(in_valid), .in_data(in_data),
        .out_valid(vld_b), .out_data(dat_b), .sat_flag(sat_b));

    function automatic logic [NCH*IW-1:0] pk(input int c0, input int c1);
        return {IW'(c1), IW'(c0)};
    endfunction

    // Ideal decimated output: y[n] = sum h[k] x[n-k], h = boxcar(R) convolved N times, then scaled.
    function automatic void ch_out(input int ch, input int ow, output int v, output bit c);
        int     rr;
        int     h[$];
        int     t[$];
        int     s;
        int     sh;
        longint y;
        longint hi;
        longint lo;
        logic [NCH*IW-1:0] w;
        rr = 1 << m_r;
        h  = '{1};
        repeat (N) begin
            t = {};
            for (int i = 0; i < h.size() + rr - 1; i++) begin
                s = 0;
                for (int j = 0; j < rr; j++)
                    if (i - j >= 0 && i - j < h.size()) s += h[i-j];
                t.push_back(s);
            end
            h = t;
        end
        y = 0;
        for (int k = 0; k < h.size() && k < hist.size(); k++) begin
            w = hist[hist.size()-1-k];
            y += longint'(h[k]) * longint'($signed(w[ch*IW +: IW]));
        end
        sh = IW + N * m_r - ow;
        if (sh > 0) y = (y + (longint'(1) <<< (sh - 1))) >>> sh;
        else        y = y <<< (-sh);
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -(longint'(1) <<< (ow - 1));
        c  = 1'b0;
        if (y > hi) begin y = hi; c = 1'b1; end
        else if (y < lo) begin y = lo; c = 1'b1; end
        v = int'(y);
    endfunction

    // Apply one cycle of inputs, advance the clock and update the model for that edge.
    task automatic drive(input bit rs, input int rate, input bit v, input logic [NCH*IW-1:0] d);
        int                 rc;
        int                 val;
        bit                 c;
        logic [NCH*OWA-1:0] ea;
        logic [NCH*OWB-1:0] eb;
        logic [NCH-1:0]     sa;
        logic [NCH-1:0]     sb;
        rst = rs; rate_log2 = 3'(rate); in_valid = v; in_data = d;
        @(posedge clk);
        cyc++;
        rc    = (rate > RMAX) ? RMAX : rate;
        e_vld = 1'b0;
        if (rs || rc != m_r) begin
            hist.delete(); pdue.delete(); pa.delete(); pb.delete(); psa.delete(); psb.delete();
            taps = 0;
            m_r  = rc;
            if (rs) begin
                e_da = '0; e_db = '0; e_sa = '0; e_sb = '0;
            end
        end else begin
            if (pdue.size() > 0 && pdue[0] == cyc) begin
                void'(pdue.pop_front());
                e_vld = 1'b1;
                e_da  = pa.pop_front();
                e_db  = pb.pop_front();
                e_sa  = e_sa | psa.pop_front();
                e_sb  = e_sb | psb.pop_front();
            end
            if (v) begin
                hist.push_back(d);
                if (hist.size() % (1 << m_r) == 0) begin
                    taps++;
                    if (taps > N) begin
                        for (int ch = 0; ch < NCH; ch++) begin
                            ch_out(ch, OWA, val, c); ea[ch*OWA +: OWA] = OWA'(val); sa[ch] = c;
                            ch_out(ch, OWB, val, c); eb[ch*OWB +: OWB] = OWB'(val); sb[ch] = c;
                        end
                        pdue.push_back(cyc + N + 1);
                        pa.push_back(ea); pb.push_back(eb); psa.push_back(sa); psb.push_back(sb);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 4, 1, pk(123, -45));
        drive(1, 4, 0, '0);
        if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== '0) begin
            errors++;
            $display("FAIL reset_state got a=%b %h %b b=%b %h %b, want all zero", vld_a, dat_a, sat_a, vld_b, dat_b, sat_b);
        end
        checks++;
    endtask

    task automatic test_dc();
        int start, nstb, last;
        logic [NCH*OWA-1:0] want;
        want = {14'd1000, 14'd1000};
        drive(1, 4, 0, '0);
        start = cyc; nstb = 0; last = 0;
        for (int i = 0; i < 7 * 16 + N + 1; i++) begin
            drive(0, 4, 1, pk(1000, 1000));
            if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== {e_vld, e_da, e_sa, e_vld, e_db, e_sb}) begin
                errors++;
                $display("FAIL dc_cycle cyc=%0d got a=%b %h %b b=%b %h %b, want a=%b %h %b b=%b %h %b",
                         cyc, vld_a, dat_a, sat_a, vld_b, dat_b, sat_b, e_vld, e_da, e_sa, e_vld, e_db, e_sb);
            end
            checks++;
            if (vld_a) begin
                nstb++;
                if (nstb == 1 && cyc != start + 3 * 16 + N + 1) begin
                    errors++;
                    $display("FAIL dc_first_strobe got cyc %0d, want %0d", cyc - start, 3 * 16 + N + 1);
                end
                if (nstb > 1 && cyc - last != 16) begin
                    errors++;
                    $display("FAIL dc_period got %0d, want 16", cyc - last);
                end
                if (dat_a !== want) begin
                    errors++;
                    $display("FAIL dc_value got %h, want %h", dat_a, want);
                end
                checks += 2;
                last = cyc;
            end
        end
        if (nstb != 5) begin
            errors++;
            $display("FAIL dc_strobe_count got %0d, want 5", nstb);
        end
        checks++;
    endtask

    task automatic test_extremes();
        logic [NCH*OWA-1:0] wa;
        logic [NCH*OWB-1:0] wb;
        wa = {14'h2000, 14'h1FFF};
        wb = {12'h800, 12'h7FF};
        drive(1, 4, 0, '0);
        for (int i = 0; i < 8 * 16; i++) begin
            drive(0, 4, 1, (i < 5 * 16 + N + 1) ? pk(8191, -8192) : pk(0, 0));
            if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== {e_vld, e_da, e_sa, e_vld, e_db, e_sb}) begin
                errors++;
                $display("FAIL extremes_cycle cyc=%0d got a=%b %h %b b=%b %h %b, want a=%b %h %b b=%b %h %b",
                         cyc, vld_a, dat_a, sat_a, vld_b, dat_b, sat_b, e_vld, e_da, e_sa, e_vld, e_db, e_sb);
            end
            checks++;
            if (i == 5 * 16 + N) begin
                if (dat_a !== wa || sat_a !== 2'b00 || dat_b !== wb || sat_b !== 2'b01) begin
                    errors++;
                    $display("FAIL extremes_value got a=%h sat %b b=%h sat %b, want a=%h sat 00 b=%h sat 01",
                             dat_a, sat_a, dat_b, sat_b, wa, wb);
                end
                checks++;
            end
        end
        if (sat_b !== 2'b01 || sat_a !== 2'b00) begin
            errors++;
            $display("FAIL sat_sticky got a=%b b=%b, want a=00 b=01", sat_a, sat_b);
        end
        checks++;
    endtask

    task automatic test_round();
        logic [NCH*OWB-1:0] wb;
        wb = {12'hFFF, 12'h001};
        drive(1, 4, 0, '0);
        for (int i = 0; i < 5 * 16 + N + 1; i++) begin
            drive(0, 4, 1, pk(3, -3));
            if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== {e_vld, e_da, e_sa, e_vld, e_db, e_sb}) begin
                errors++;
                $display("FAIL round_cycle cyc=%0d got a=%b %h %b b=%b %h %b, want a=%b %h %b b=%b %h %b",
                         cyc, vld_a, dat_a, sat_a, vld_b, dat_b, sat_b, e_vld, e_da, e_sa, e_vld, e_db, e_sb);
            end
            checks++;
        end
        if (dat_b !== wb) begin
            errors++;
            $display("FAIL round_value got %h, want %h", dat_b, wb);
        end
        checks++;
    endtask

    task automatic test_rate_change();
        int chg, nstb, last;
        logic [NCH*OWA-1:0] want;
        want = {14'd500, 14'd500};
        drive(1, 4, 0, '0);
        for (int i = 0; i < 24 + 44 + 1; i++) begin
            drive(0, (i < 24) ? 4 : 2, 1, pk(500, 500));
            if (i == 24) begin chg = cyc; nstb = 0; last = 0; end
            if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== {e_vld, e_da, e_sa, e_vld, e_db, e_sb}) begin
                errors++;
                $display("FAIL rate_cycle cyc=%0d got a=%b %h %b b=%b %h %b, want a=%b %h %b b=%b %h %b",
                         cyc, vld_a, dat_a, sat_a, vld_b, dat_b, sat_b, e_vld, e_da, e_sa, e_vld, e_db, e_sb);
            end
            checks++;
            if (i > 24 && vld_a) begin
                nstb++;
                if ((nstb == 1 && cyc - chg != 15) || (nstb > 1 && cyc - last != 4) || dat_a !== want) begin
                    errors++;
                    $display("FAIL rate_strobe n=%0d got offset %0d value %h, want offset %0d value %h",
                             nstb, cyc - chg, dat_a, (nstb == 1) ? 15 : last - chg + 4, want);
                end
                checks++;
                last = cyc;
            end
        end
        if (nstb != 8) begin
            errors++;
            $display("FAIL rate_strobe_count got %0d, want 8", nstb);
        end
        checks++;
    endtask

    task automatic test_gaps();
        int start, nstb, last;
        logic [NCH*OWA-1:0] want;
        want = {14'd200, 14'd200};
        drive(1, 1, 0, '0);
        start = cyc; nstb = 0; last = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, (i % 2) == 0, pk(200, 200));
            if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== {e_vld, e_da, e_sa, e_vld, e_db, e_sb}) begin
                errors++;
                $display("FAIL gaps_cycle cyc=%0d got a=%b %h %b b=%b %h %b, want a=%b %h %b b=%b %h %b",
                         cyc, vld_a, dat_a, sat_a, vld_b, dat_b, sat_b, e_vld, e_da, e_sa, e_vld, e_db, e_sb);
            end
            checks++;
            if (vld_a) begin
                nstb++;
                if ((nstb == 1 && cyc - start != 14) || (nstb > 1 && cyc - last != 4) || dat_a !== want) begin
                    errors++;
                    $display("FAIL gaps_strobe n=%0d got offset %0d value %h, want offset %0d value %h",
                             nstb, cyc - start, dat_a, (nstb == 1) ? 14 : last - start + 4, want);
                end
                checks++;
                last = cyc;
            end
        end
        if (nstb != 7) begin
            errors++;
            $display("FAIL gaps_strobe_count got %0d, want 7", nstb);
        end
        checks++;
        drive(0, 1, 1, pk(200, 200));
        drive(1, 1, 1, pk(200, 200));
        if (vld_a !== 1'b0 || dat_a !== '0 || vld_b !== 1'b0 || dat_b !== '0) begin
            errors++;
            $display("FAIL midframe_reset got a=%b %h b=%b %h, want zero", vld_a, dat_a, vld_b, dat_b);
        end
        checks++;
    endtask

    task automatic test_random();
        int rate;
        rate = 4;
        drive(1, rate, 0, '0);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) rate = $urandom_range(0, 7);
            drive($urandom_range(0, 499) == 0, rate, $urandom_range(0, 3) != 0, (NCH*IW)'($urandom));
            if ({vld_a, dat_a, sat_a, vld_b, dat_b, sat_b} !== {e_vld, e_da, e_sa, e_vld, e_db, e_sb}) begin
                errors++;
                $display("FAIL random_cycle cyc=%0d r=%0d got a=%b %h %b b=%b %h %b, want a=%b %h %b b=%b %h %b",
                         cyc, m_r, vld_a, dat_a, sat_a, vld_b, dat_b, sat_b, e_vld, e_da, e_sa, e_vld, e_db, e_sb);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_extremes();
        test_round();
        test_rate_change();
        test_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
